bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 195 +++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter placed after the N-bit accumulator. It
// turns the accumulator sum into D packed decimal digits for the board's
// seven-segment drivers. A start pulse in IDLE captures the sum and its
// overflow flag. A shift-and-add-3 (double-dabble) engine then consumes one
// input bit per clock. Finally the digits, the overflow flag and a one-cycle
// done strobe are presented. These results are held until the next
// conversion completes.
//
// Parameters
//   N       width of the binary input (default 8)
//   D       number of BCD digits produced; 10^D must exceed 2^N - 1
//
// Ports
//   clk     in   1     rising-edge clock (shared with the accumulator)
//   aclr    in   1     asynchronous active-low reset
//   start   in   1     conversion request, sampled only while IDLE
//   bin     in   N     binary value to convert (accumulator sum)
//   ovf_in  in   1     accumulator overflow flag, captured together with bin
//   busy    out  1     high while a conversion is in progress
//   done    out  1     one-cycle pulse when new results become valid
//   bcd     out  4*D   packed digits, bcd[3:0] = ones, bcd[7:4] = tens, ...
//   ovf     out  1     ovf_in as captured for the displayed result
//   neg     out  1     sign of the displayed result
//
// Build option
//   BCD_SIGNED_EN  when defined, bin is two's complement. Its magnitude is
//                  converted and neg shows its sign. When it is not defined,
//                  bin is unsigned and neg is tied to 0.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
  parameter int N = 8,
  parameter int D = 3
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             start,
  input  logic [N-1:0]     bin,
  input  logic             ovf_in,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   bcd,
  output logic             ovf,
  output logic             neg
);

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(N);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]     state_q,   state_d;
  logic [CW-1:0]  count_q,   count_d;
  logic [N-1:0]   shift_q,   shift_d;
  logic [4*D-1:0] scratch_q, scratch_d;
  logic [4*D-1:0] bcd_q,     bcd_d;
  logic           ovfCap_q,  ovfCap_d;
  logic           ovf_q,     ovf_d;
  logic           done_q,    done_d;

  logic [N-1:0]     loadValue;
  logic [4*D-1:0]   adjusted;
  logic [4*D+N-1:0] shifted;

`ifdef BCD_SIGNED_EN
  logic negCap_q, negCap_d;
  logic neg_q,    neg_d;

  // In signed mode the engine works on the magnitude. The N-bit negate of
  // the most negative code wraps back to 2^(N-1). Read as unsigned, that is
  // exactly the magnitude we want, so no extra bit is needed.
  assign loadValue = bin[N-1] ? (-bin) : bin;
`else
  assign loadValue = bin;
`endif

  // Double-dabble correction step. Any digit of 5 or more gets 3 added
  // before the shift, so that it carries correctly into the next decade
  // when it is doubled.
  always_comb begin
    adjusted = '0;
    for (int i = 0; i < D; i++) begin
      adjusted[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ?
                           (scratch_q[4*i +: 4] + 4'd3) :
                           scratch_q[4*i +: 4];
    end
    shifted = {adjusted, shift_q} << 1;
  end

  // Control and datapath next-state logic.
  // In IDLE, a start loads the engine and arms the bit counter.
  // In SHIFT, each clock consumes one bit until the counter is exhausted.
  // The edge after that publishes the result and returns to IDLE.
  // The publish edge is a separate edge so that the result registers are
  // loaded from registered scratch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bcd_d     = bcd_q;
    ovfCap_d  = ovfCap_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
`ifdef BCD_SIGNED_EN
    negCap_d  = negCap_q;
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = loadValue;
          scratch_d = '0;
          ovfCap_d  = ovf_in;
          count_d   = CNT_LOAD;
          state_d   = SHIFT;
`ifdef BCD_SIGNED_EN
          negCap_d  = bin[N-1];
`endif
        end
      end
      SHIFT: begin
        if (count_q != '0) begin
          scratch_d = shifted[4*D+N-1:N];
          shift_d   = shifted[N-1:0];
          count_d   = count_q - CNT_ONE;
        end else begin
          bcd_d   = scratch_q;
          ovf_d   = ovfCap_q;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef BCD_SIGNED_EN
          neg_d   = negCap_q;
`endif
        end
      end
    endcase
  end

  // State and datapath registers. The reset is asynchronous and aborts any
  // conversion in flight. It clears every output so that the display
  // blanks to zero straight away.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q   <= IDLE;
      count_q   <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      bcd_q     <= '0;
      ovfCap_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bcd_q     <= bcd_d;
      ovfCap_q  <= ovfCap_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

`ifdef BCD_SIGNED_EN
  // The sign capture and the displayed sign follow the same
  // capture/publish rhythm as the overflow flag.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      negCap_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      negCap_q <= negCap_d;
      neg_q    <= neg_d;
    end
  end

  assign neg = neg_q;
`else
  assign neg = 1'b0;
`endif

  // Every output comes straight from a register. busy is the decoded
  // registered state, so no input reaches an output combinationally.
  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Self-checking bench for bin_to_bcd_seq (N=8, D=3). A behavioural model
// predicts the outputs from the decimal value of the captured input and a
// latency of N+1 clocks. A compare process checks every output against the
// model on each falling edge. Directed tests add literal expectations
// computed by hand. The same bench also builds with BCD_SIGNED_EN.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

  localparam int N = 8;
  localparam int D = 3;

`ifdef BCD_SIGNED_EN
  localparam logic [11:0] EXP_FF  = 12'h001;
  localparam logic [11:0] EXP_A5  = 12'h091;
  localparam logic [11:0] EXP_200 = 12'h056;
  localparam logic        NEG_FF  = 1'b1;
`else
  localparam logic [11:0] EXP_FF  = 12'h255;
  localparam logic [11:0] EXP_A5  = 12'h165;
  localparam logic [11:0] EXP_200 = 12'h200;
  localparam logic        NEG_FF  = 1'b0;
`endif

  logic           clk    = 1'b0;
  logic           aclr   = 1'b1;
  logic           start  = 1'b0;
  logic [N-1:0]   bin    = '0;
  logic           ovf_in = 1'b0;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
  logic           ovf;
  logic           neg;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  bin_to_bcd_seq #(.N(N), .D(D)) dut (
    .clk    (clk),
    .aclr   (aclr),
    .start  (start),
    .bin    (bin),
    .ovf_in (ovf_in),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd),
    .ovf    (ovf),
    .neg    (neg)
  );

  always #5 clk = ~clk;

  // Model state: the number of clocks left in the conversion, and the
  // captured request.
  int             mLeft = 0;
  bit             mDone = 1'b0;
  bit             mOvf  = 1'b0;
  bit             mNeg  = 1'b0;
  logic [4*D-1:0] mBcd  = '0;
  int             pVal  = 0;
  bit             pOvf  = 1'b0;
  bit             pNeg  = 1'b0;

  // Decimal magnitude of the input value, as the display should show it.
  function automatic int magnitude(input logic [N-1:0] v);
    int s;
    s = int'(v);
`ifdef BCD_SIGNED_EN
    if (v[N-1]) s = s - (1 << N);
`endif
    return (s < 0) ? -s : s;
  endfunction

  function automatic bit signOf(input logic [N-1:0] v);
`ifdef BCD_SIGNED_EN
    return v[N-1];
`else
    return 1'b0;
`endif
  endfunction

  // Packs the decimal digits of v, using plain division.
  function automatic logic [4*D-1:0] toBcd(input int v);
    logic [4*D-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int d = 0; d < D; d++) begin
      r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. A request is taken only when the model is not busy.
  // Results appear N+1 clocks after it is taken.
  always @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      mLeft <= 0;
      mDone <= 1'b0;
      mBcd  <= '0;
      mOvf  <= 1'b0;
      mNeg  <= 1'b0;
    end else if (mLeft > 0) begin
      mLeft <= mLeft - 1;
      mDone <= (mLeft == 1);
      if (mLeft == 1) begin
        mBcd <= toBcd(pVal);
        mOvf <= pOvf;
        mNeg <= pNeg;
      end
    end else begin
      mDone <= 1'b0;
      if (start) begin
        pVal  <= magnitude(bin);
        pOvf  <= ovf_in;
        pNeg  <= signOf(bin);
        mLeft <= N + 1;
      end
    end
  end

  // Compares every output against the model on each falling edge.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cmp_busy", 64'(busy), 64'(mLeft > 0));
      checkOutput("cmp_done", 64'(done), 64'(mDone));
      checkOutput("cmp_bcd",  64'(bcd),  64'(mBcd));
      checkOutput("cmp_ovf",  64'(ovf),  64'(mOvf));
      checkOutput("cmp_neg",  64'(neg),  64'(mNeg));
    end
  end

  // Called at a falling edge. The request is visible at the next rising edge
  // and is dropped at the falling edge after that.
  task automatic applyStimulus(input logic [N-1:0] value, input logic ovfv);
    start  = 1'b1;
    bin    = value;
    ovf_in = ovfv;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Waits at falling edges until done is seen, and counts busy cycles.
  task automatic waitDone(input string name, output int busyCycles);
    bit seen;
    busyCycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busyCycles++;
        @(negedge clk);
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_timeout: got no done, required done within 40 cycles", name);
    end
  endtask

  int bc;
  int dones;
  int nDone;
  int firstIdx;
  int secondIdx;
  bit dropNext;
  logic [4*D-1:0] b1;
  logic [4*D-1:0] b2;

  initial begin
    #1 aclr = 1'b0;
    checking = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_bcd",  64'(bcd),  64'd0);
    checkOutput("rst_ovf",  64'(ovf),  64'd0);
    checkOutput("rst_neg",  64'(neg),  64'd0);
    aclr = 1'b1;
    @(negedge clk);

    // Zero input.
    applyStimulus(8'd0, 1'b0);
    waitDone("t0", bc);
    checkOutput("t0_bcd",  64'(bcd), 64'h000);
    checkOutput("t0_ovf",  64'(ovf), 64'd0);
    checkOutput("t0_busy_cycles", 64'(bc), 64'd9);
    @(negedge clk);

    // Full-scale input with the overflow flag set.
    applyStimulus(8'd255, 1'b1);
    waitDone("t255", bc);
    checkOutput("t255_bcd", 64'(bcd), 64'(EXP_FF));
    checkOutput("t255_ovf", 64'(ovf), 64'd1);
    checkOutput("t255_neg", 64'(neg), 64'(NEG_FF));
    checkOutput("t255_busy_cycles", 64'(bc), 64'd9);
    @(negedge clk);
    checkOutput("t255_done_width", 64'(done), 64'd0);
    checkOutput("t255_hold_bcd", 64'(bcd), 64'(EXP_FF));

    // Start pulses while busy are ignored, and so is a change of bin.
    applyStimulus(8'hA5, 1'b0);
    start = 1'b1; bin = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checkOutput("tA5_done_count", 64'(dones), 64'd1);
    checkOutput("tA5_bcd", 64'(bcd), 64'(EXP_A5));

    // Asynchronous reset in the middle of a conversion.
    applyStimulus(8'd99, 1'b0);
    repeat (3) @(negedge clk);
    #2 aclr = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_done", 64'(done), 64'd0);
    checkOutput("arst_bcd",  64'(bcd),  64'd0);
    @(negedge clk);
    #2 aclr = 1'b1;
    @(negedge clk);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checkOutput("arst_no_done", 64'(dones), 64'd0);
    applyStimulus(8'd99, 1'b0);
    waitDone("t99", bc);
    checkOutput("t99_bcd", 64'(bcd), 64'h099);
    @(negedge clk);

    // Back to back with start held high. The next request is taken on the
    // edge that ends done.
    start = 1'b1; bin = 8'd7; ovf_in = 1'b0;
    @(negedge clk);
    bin = 8'd200;
    nDone = 0; firstIdx = 0; secondIdx = 0; dropNext = 1'b0;
    b1 = '0; b2 = '0;
    for (int i = 0; i < 40 && nDone < 2; i++) begin
      if (dropNext) begin
        start = 1'b0;
        dropNext = 1'b0;
      end
      if (done) begin
        if (nDone == 0) begin
          firstIdx = i; b1 = bcd; dropNext = 1'b1;
        end else begin
          secondIdx = i; b2 = bcd;
        end
        nDone++;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("b2b_count", 64'(nDone), 64'd2);
    checkOutput("b2b_first_bcd", 64'(b1), 64'h007);
    checkOutput("b2b_second_bcd", 64'(b2), 64'(EXP_200));
    checkOutput("b2b_spacing", 64'(secondIdx - firstIdx), 64'(N + 2));

`ifdef BCD_SIGNED_EN
    // Signed corner cases.
    @(negedge clk);
    applyStimulus(8'h80, 1'b0);
    waitDone("s80", bc);
    checkOutput("s80_bcd", 64'(bcd), 64'h128);
    checkOutput("s80_neg", 64'(neg), 64'd1);
    @(negedge clk);
    applyStimulus(8'hFF, 1'b0);
    waitDone("sFF", bc);
    checkOutput("sFF_bcd", 64'(bcd), 64'h001);
    checkOutput("sFF_neg", 64'(neg), 64'd1);
    @(negedge clk);
    applyStimulus(8'h7F, 1'b0);
    waitDone("s7F", bc);
    checkOutput("s7F_bcd", 64'(bcd), 64'h127);
    checkOutput("s7F_neg", 64'(neg), 64'd0);
`endif

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
